// File: rtl/elevator_door_ctrl.sv
// elevator_door_ctrl: timed open/dwell/close door sequencer that inhibits car motion while the door is not shut
module elevator_door_ctrl #(
  parameter int MOVE_CYCLES  = 4,
  parameter int DWELL_CYCLES = 10,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       complete,
  input  logic [2:0] out_floor,
  input  logic       over_weight,
  input  logic       obstruct,
  input  logic       open_btn,
  input  logic       close_btn,
  output logic [1:0] door_state,
  output logic       door_open_cmd,
  output logic       door_close_cmd,
  output logic       motion_inhibit,
  output logic [2:0] door_floor,
  output logic       arrive_pulse
);
  typedef enum logic [1:0] {CLOSED, OPENING, OPEN, CLOSING} state_t;
  localparam logic [CNT_W-1:0] MV = CNT_W'(MOVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DW = CNT_W'(DWELL_CYCLES - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0] floor_n;
  logic complete_q, pulse_n, rise, hold, cnt_z;
  assign rise = complete & ~complete_q;
  assign hold = obstruct | over_weight | open_btn;
  assign cnt_z = cnt == '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLOSED;
      cnt <= '0;
      complete_q <= 1'b1;
      door_floor <= '0;
      arrive_pulse <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      complete_q <= complete;
      door_floor <= floor_n;
      arrive_pulse <= pulse_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt - 1'b1;
    floor_n = door_floor;
    pulse_n = 1'b0;
    case (state)
      CLOSED: begin
        cnt_n = cnt;
        if (rise | (open_btn & complete)) begin
          state_n = OPENING;
          cnt_n = MV;
          floor_n = out_floor;
          pulse_n = 1'b1;
        end
      end
      OPENING: if (cnt_z) begin
        state_n = OPEN;
        cnt_n = DW;
      end
      OPEN: begin
        if (hold) cnt_n = DW;
        else if (close_btn | cnt_z) begin
          state_n = CLOSING;
          cnt_n = MV;
        end
      end
      default: begin
        // reversal retraces only the distance already closed
        if (hold) begin
          state_n = OPENING;
          cnt_n = MV - cnt;
        end else if (cnt_z) state_n = CLOSED;
      end
    endcase
  end
  assign door_state = state;
  assign door_open_cmd = state == OPENING;
  assign door_close_cmd = state == CLOSING;
  assign motion_inhibit = state != CLOSED;
endmodule

// File: tb/tb_elevator_door_ctrl.sv
// tb_elevator_door_ctrl: directed checks of the door cycle, dwell restart, reversal and reset
module tb_elevator_door_ctrl;
  logic clk = 0, rst_n = 0, complete = 0, over_weight = 0, obstruct = 0, open_btn = 0, close_btn = 0;
  logic [2:0] out_floor = 0;
  logic [1:0] door_state;
  logic door_open_cmd, door_close_cmd, motion_inhibit, arrive_pulse;
  logic [2:0] door_floor;
  int checks = 0, errors = 0;
  localparam logic [1:0] CLOSED = 0, OPENING = 1, OPEN = 2, CLOSING = 3;

  elevator_door_ctrl dut (
    .clk(clk), .rst_n(rst_n), .complete(complete), .out_floor(out_floor),
    .over_weight(over_weight), .obstruct(obstruct), .open_btn(open_btn),
    .close_btn(close_btn), .door_state(door_state), .door_open_cmd(door_open_cmd),
    .door_close_cmd(door_close_cmd), .motion_inhibit(motion_inhibit),
    .door_floor(door_floor), .arrive_pulse(arrive_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // state plus its decoded outputs: {state, open_cmd, close_cmd, inhibit}
  task automatic chk_st(string tag, logic [1:0] st);
    chk(tag, {3'b0, door_state, door_open_cmd, door_close_cmd, motion_inhibit},
        {3'b0, st, st == OPENING, st == CLOSING, st != CLOSED});
  endtask

  task automatic hold_st(string tag, logic [1:0] st, int n);
    for (int i = 0; i < n; i++) begin
      chk_st(tag, st);
      tick();
    end
  endtask

  initial begin
    tick(2);
    chk_st("reset_state", CLOSED);
    chk("reset_floor", {5'b0, door_floor}, 8'd0);
    chk("reset_pulse", {7'b0, arrive_pulse}, 8'd0);
    rst_n = 1;
    tick(2);
    // 1: rising complete at floor 5
    out_floor = 5;
    complete = 1;
    tick();
    chk("t1_pulse_hi", {7'b0, arrive_pulse}, 8'd1);
    chk("t1_floor", {5'b0, door_floor}, 8'd5);
    chk_st("t1_opening0", OPENING);
    tick();
    chk("t1_pulse_lo", {7'b0, arrive_pulse}, 8'd0);
    hold_st("t1_opening", OPENING, 3);
    hold_st("t1_open", OPEN, 10);
    hold_st("t1_closing", CLOSING, 4);
    chk_st("t1_closed", CLOSED);
    // 2: complete high through reset must not open
    rst_n = 0;
    tick();
    rst_n = 1;
    hold_st("t2_no_open", CLOSED, 3);
    out_floor = 3;
    open_btn = 1;
    tick();
    open_btn = 0;
    chk("t2_pulse", {7'b0, arrive_pulse}, 8'd1);
    chk("t2_floor", {5'b0, door_floor}, 8'd3);
    hold_st("t2_opening", OPENING, 4);
    hold_st("t2_open", OPEN, 10);
    hold_st("t2_closing", CLOSING, 4);
    chk_st("t2_closed", CLOSED);
    // 3: obstruct for 3 cycles from the 5th OPEN cycle
    complete = 0;
    tick();
    out_floor = 2;
    complete = 1;
    tick();
    hold_st("t3_opening", OPENING, 4);
    hold_st("t3_open_pre", OPEN, 4);
    obstruct = 1;
    hold_st("t3_obstructed", OPEN, 3);
    obstruct = 0;
    hold_st("t3_dwell", OPEN, 10);
    chk_st("t3_closing", CLOSING);
    // 4: over_weight at the 2nd CLOSING cycle reverses for 2 cycles
    tick();
    chk_st("t4_closing2", CLOSING);
    over_weight = 1;
    tick();
    over_weight = 0;
    chk("t4_no_pulse", {7'b0, arrive_pulse}, 8'd0);
    chk("t4_floor_kept", {5'b0, door_floor}, 8'd2);
    hold_st("t4_reopening", OPENING, 2);
    hold_st("t4_open", OPEN, 10);
    hold_st("t4_closing", CLOSING, 4);
    chk_st("t4_closed", CLOSED);
    // 5: close_btn on first OPEN cycle, then both buttons in OPEN
    out_floor = 6;
    open_btn = 1;
    tick();
    open_btn = 0;
    chk("t5_floor", {5'b0, door_floor}, 8'd6);
    hold_st("t5_opening", OPENING, 4);
    chk_st("t5_open1", OPEN);
    close_btn = 1;
    tick();
    close_btn = 0;
    chk_st("t5_close_now", CLOSING);
    open_btn = 1;
    close_btn = 1;
    tick();
    open_btn = 0;
    close_btn = 0;
    chk_st("t5_both_closing", OPENING);
    chk("t5_rev_no_pulse", {7'b0, arrive_pulse}, 8'd0);
    tick();
    hold_st("t5_open_pre", OPEN, 4);
    open_btn = 1;
    close_btn = 1;
    tick();
    open_btn = 0;
    close_btn = 0;
    hold_st("t5_restarted", OPEN, 10);
    hold_st("t5_closing", CLOSING, 4);
    chk_st("t5_closed", CLOSED);
    // 6: open_btn ignored while moving; reset while OPEN
    complete = 0;
    tick();
    open_btn = 1;
    hold_st("t6_moving", CLOSED, 3);
    open_btn = 0;
    out_floor = 4;
    complete = 1;
    tick();
    hold_st("t6_opening", OPENING, 4);
    chk_st("t6_open", OPEN);
    rst_n = 0;
    tick();
    chk_st("t6_rst_state", CLOSED);
    chk("t6_rst_floor", {5'b0, door_floor}, 8'd0);
    chk("t6_rst_pulse", {7'b0, arrive_pulse}, 8'd0);
    rst_n = 1;
    hold_st("t6_after_rst", CLOSED, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/elevator_door_ctrl.md
# elevator_door_ctrl

Door controller that sits directly downstream of the elevator car controller. It consumes the car's `complete`, `out_floor` and `over_weight` outputs and sequences a timed door cycle: open, dwell, close. It handles obstruction, over-weight and cab open/close buttons. While the door is not fully closed it asserts `motion_inhibit`, which gates the car's motion enable.

## Interface
Parameters:
- `MOVE_CYCLES`, default 4: clock cycles the door takes to travel fully open or fully closed; must be ≥1.
- `DWELL_CYCLES`, default 10: clock cycles the door stays fully open before closing; must be ≥1.
- `CNT_W`, default 8: timer width; must satisfy 2^CNT_W > max(MOVE_CYCLES, DWELL_CYCLES).

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `complete` in 1: car-at-target flag from the car controller; level signal.
- `out_floor` in 3: current car floor from the car controller.
- `over_weight` in 1: car load above limit.
- `obstruct` in 1: light-curtain beam broken; level signal.
- `open_btn` in 1: cab door-open button; level signal.
- `close_btn` in 1: cab door-close button; level signal.
- `door_state` out 2: CLOSED=0, OPENING=1, OPEN=2, CLOSING=3.
- `door_open_cmd` out 1: drive door motor open; high iff state is OPENING.
- `door_close_cmd` out 1: drive door motor closed; high iff state is CLOSING.
- `motion_inhibit` out 1: high iff state ≠ CLOSED.
- `door_floor` out 3: floor at which the current/last door cycle started.
- `arrive_pulse` out 1: one-cycle pulse on each CLOSED→OPENING transition.

## Operation
- Moore FSM with a down-counter `cnt` (CNT_W bits). All outputs are decoded from registered state, so none is combinational from inputs.
- `complete_q` registers `complete`. A rising edge is `rise = complete & ~complete_q`.
- Transitions from CLOSED:
  - → OPENING on `rise`, or on `open_btn & complete`.
  - On that transition: `cnt` ← MOVE_CYCLES−1, `door_floor` ← `out_floor`, `arrive_pulse`=1 for the next cycle.
  - No transition while `complete`=0 (car moving): open_btn is ignored.
- Transitions from OPENING:
  - Decrement `cnt` each cycle.
  - At `cnt`==0 → OPEN with `cnt` ← DWELL_CYCLES−1.
  - Buttons, obstruct and over_weight are ignored during OPENING.
- Transitions from OPEN, in priority order:
  1. `obstruct | over_weight | open_btn` → `cnt` ← DWELL_CYCLES−1 (dwell restarts), stay OPEN.
  2. else `close_btn` → CLOSING, `cnt` ← MOVE_CYCLES−1.
  3. else `cnt`==0 → CLOSING, `cnt` ← MOVE_CYCLES−1.
  4. else decrement `cnt`.
- Transitions from CLOSING:
  - `obstruct | over_weight | open_btn` → OPENING with `cnt` ← MOVE_CYCLES−1−`cnt` (reverse: door retraces the distance already closed). No `arrive_pulse` on reversal.
  - else at `cnt`==0 → CLOSED.
  - else decrement `cnt`.
- Simultaneous `open_btn` and `close_btn`: open wins in every state.
- `rise` arriving in any state other than CLOSED is discarded; it does not queue.
- `door_floor` is updated only on CLOSED→OPENING.

## Timing
- Reset (`rst_n`=0 at a clock edge):
  - `door_state`=CLOSED, `door_open_cmd`=0, `door_close_cmd`=0, `motion_inhibit`=0, `door_floor`=0, `arrive_pulse`=0, `cnt`=0.
  - `complete_q`=1, so a `complete` already high out of reset does not open the door.
- Reset mid-cycle (any state) forces CLOSED on that edge, with no intermediate CLOSING.
- Latency:
  - `rise` sampled at edge T → OPENING (and `motion_inhibit`=1) visible after edge T.
  - OPENING lasts exactly MOVE_CYCLES cycles.
  - OPEN lasts DWELL_CYCLES cycles if not extended.
  - CLOSING lasts MOVE_CYCLES cycles.
  - CLOSED again after edge T+2·MOVE_CYCLES+DWELL_CYCLES.
- `close_btn` sampled in OPEN at edge E → CLOSING after edge E.
- Reversal at a CLOSING cycle with `cnt`=c → OPENING lasts MOVE_CYCLES−c cycles.
- `motion_inhibit` falls on the same edge the state enters CLOSED.

## Test plan
1. Reset, then `complete` 0→1 at edge 10, `out_floor`=5 (defaults):
   - `arrive_pulse` high for cycle 10→11 only; `door_floor`=5.
   - OPENING for edges 10–13, OPEN 14–23, CLOSING 24–27, CLOSED at edge 28.
   - `motion_inhibit` high from edge 10 to edge 28.
2. `complete`=1 held through reset release → door stays CLOSED; `open_btn` pulse then → full door cycle.
3. `obstruct` high for 3 cycles starting on the 5th OPEN cycle → dwell restarts on each of those cycles; CLOSING begins 10 cycles after `obstruct` drops.
4. `over_weight` asserted at the 2nd CLOSING cycle (`cnt`=2) → OPENING for 2 cycles, then OPEN 10 cycles; no second `arrive_pulse`; `door_floor` unchanged.
5. `close_btn` on the 1st OPEN cycle → CLOSING next cycle. `open_btn`+`close_btn` together in OPEN → stays OPEN with dwell restarted.
6. `open_btn` while `complete`=0 → no state change. Assert `rst_n`=0 while OPEN → all outputs at their reset values after that edge.
